summer_tiny_tapeout: RTL and testbench

//  - 16-bit command-driven accumulator ("summer") in the standard TinyTapeout user-project wrapper.
//  - Byte operands arrive on ui_in; opcode and strobe arrive on uio_in[3:0].
//  - Accumulator byte readout on uo_out; status flags on uio_out[7:5].
//  - Top-level user block, instantiated directly by the chip harness / testbench.

---
 rtl/summer_tiny_tapeout.sv | 112 +++++++++++
 tb/tb_summer_tiny_tapeout.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/summer_tiny_tapeout.sv
// summer_tiny_tapeout: 16-bit command-driven accumulator in a TinyTapeout wrapper.
// Byte operands arrive on ui_in; opcode/strobe/read-select on uio_in; the selected
// accumulator byte is shown on uo_out and the status flags on uio_out[7:5].
// Optional feature: define SUMMER_SATURATE_EN to clamp ADD/SUB instead of wrapping.
module summer_tiny_tapeout (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [2:0] {
    OpNop    = 3'd0,
    OpAdd    = 3'd1,
    OpSub    = 3'd2,
    OpLoadLo = 3'd3,
    OpLoadHi = 3'd4,
    OpClear  = 3'd5,
    OpShr    = 3'd6,
    OpClrOvf = 3'd7
  } op_e;

  logic [15:0] acc_q, acc_d;
  logic        ovf_q, ovf_d;
  logic        done_q;
  logic        stb_q;
  logic        fire;
  logic        zero;
  op_e         op;
  logic [16:0] sum;
  logic [16:0] diff;

  // Upper uio_in bits carry no function.
  logic unused_uio;
  assign unused_uio = ^uio_in[7:5];

  assign op   = op_e'(uio_in[2:0]);
  // One operation per rising strobe edge; stb_q tracks even while disabled.
  assign fire = ena & uio_in[3] & ~stb_q;
  assign sum  = {1'b0, acc_q} + {9'b0, ui_in};
  // Bit 16 of the difference is the borrow out.
  assign diff = {1'b0, acc_q} - {9'b0, ui_in};

  // Next-state of accumulator and sticky overflow for a firing command.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (fire) begin
      unique case (op)
        OpNop: ;
        OpAdd: begin
          acc_d = sum[15:0];
          if (sum[16]) begin
            ovf_d = 1'b1;
`ifdef SUMMER_SATURATE_EN
            acc_d = 16'hFFFF;
`endif
          end
        end
        OpSub: begin
          acc_d = diff[15:0];
          if (diff[16]) begin
            ovf_d = 1'b1;
`ifdef SUMMER_SATURATE_EN
            acc_d = 16'h0000;
`endif
          end
        end
        OpLoadLo: begin
          acc_d = {8'h00, ui_in};
          ovf_d = 1'b0;
        end
        OpLoadHi: acc_d = {ui_in, acc_q[7:0]};
        OpClear: begin
          acc_d = 16'h0000;
          ovf_d = 1'b0;
        end
        OpShr:    acc_d = {1'b0, acc_q[15:1]};
        OpClrOvf: ovf_d = 1'b0;
        default: ;
      endcase
    end
  end

  // State registers; reset takes priority over any firing command.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= 16'h0000;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
      stb_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      done_q <= fire;
      stb_q  <= uio_in[3];
    end
  end

  // Output muxing and flags, combinational from registered state.
  always_comb begin
    zero    = (acc_q == 16'h0000);
    uo_out  = uio_in[4] ? acc_q[15:8] : acc_q[7:0];
    uio_out = {done_q, ovf_q, zero, 5'b00000};
    uio_oe  = 8'b1110_0000;
  end

endmodule

// File: tb/tb_summer_tiny_tapeout.sv
// Directed self-checking bench for summer_tiny_tapeout.
module tb_summer_tiny_tapeout;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_cmp = 0;
  int n_err = 0;

  summer_tiny_tapeout dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] NOP = 3'd0, ADD = 3'd1, SUB = 3'd2, LDLO = 3'd3, LDHI = 3'd4,
                         CLR = 3'd5, SHR = 3'd6, CLROVF = 3'd7;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reads both accumulator bytes through the select mux.
  task automatic chk_acc(input string tag, input logic [15:0] exp);
    uio_in[4] = 1'b0;
    #1 chk({tag, "_lo"}, uo_out, exp[7:0]);
    uio_in[4] = 1'b1;
    #1 chk({tag, "_hi"}, uo_out, exp[15:8]);
    uio_in[4] = 1'b0;
  endtask

  // Issues one strobed op at a negedge; checks acc/flags with done set, then done cleared.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] x,
                       input logic [15:0] exp_acc, input logic [7:0] exp_flags);
    ui_in       = x;
    uio_in[2:0] = op;
    uio_in[3]   = 1'b1;
    @(negedge clk);
    chk_acc(tag, exp_acc);
    chk({tag, "_flags"}, uio_out, exp_flags | 8'h80);
    uio_in[3] = 1'b0;
    @(negedge clk);
    chk({tag, "_flags2"}, uio_out, exp_flags);
  endtask

  initial begin
    // Reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_uio", uio_out, 8'h20);
    chk("rst_oe", uio_oe, 8'hE0);

    // Basic load/add with carry into high byte
    do_op("ldlo_f0", LDLO, 8'hF0, 16'h00F0, 8'h00);
    do_op("add_20", ADD, 8'h20, 16'h0110, 8'h00);
    do_op("nop", NOP, 8'h55, 16'h0110, 8'h00);

    // Build FFFF then overflow
    do_op("clr1", CLR, 8'h00, 16'h0000, 8'h20);
    do_op("ldhi_ff", LDHI, 8'hFF, 16'hFF00, 8'h00);
    do_op("add_ff", ADD, 8'hFF, 16'hFFFF, 8'h00);
`ifdef SUMMER_SATURATE_EN
    do_op("add_ovf", ADD, 8'h01, 16'hFFFF, 8'h40);
    do_op("clrovf1", CLROVF, 8'h00, 16'hFFFF, 8'h00);
`else
    do_op("add_ovf", ADD, 8'h01, 16'h0000, 8'h60);
    do_op("clrovf1", CLROVF, 8'h00, 16'h0000, 8'h20);
`endif

    // Underflow
    do_op("clr2", CLR, 8'h00, 16'h0000, 8'h20);
`ifdef SUMMER_SATURATE_EN
    do_op("sub_unf", SUB, 8'h01, 16'h0000, 8'h60);
    do_op("clrovf2", CLROVF, 8'h00, 16'h0000, 8'h20);
`else
    do_op("sub_unf", SUB, 8'h01, 16'hFFFF, 8'h40);
    do_op("clrovf2", CLROVF, 8'h00, 16'hFFFF, 8'h00);
`endif

    // Held strobe executes once
    do_op("ldlo_10", LDLO, 8'h10, 16'h0010, 8'h00);
    ui_in     = 8'h01;
    uio_in[2:0] = ADD;
    uio_in[3] = 1'b1;
    @(negedge clk);
    chk("hold_done1", uio_out, 8'h80);
    repeat (4) @(negedge clk);
    chk("hold_done0", uio_out, 8'h00);
    chk_acc("hold_acc", 16'h0011);
    uio_in[3] = 1'b0;
    @(negedge clk);

    // Strobe rise while disabled is dropped; enabling while held does not fire
    ena       = 1'b0;
    ui_in     = 8'h05;
    uio_in[3] = 1'b1;
    @(negedge clk);
    chk("dis_flags", uio_out, 8'h00);
    chk_acc("dis_acc", 16'h0011);
    ena = 1'b1;
    @(negedge clk);
    chk("ena_held_flags", uio_out, 8'h00);
    chk_acc("ena_held_acc", 16'h0011);
    uio_in[3] = 1'b0;
    @(negedge clk);

    // Reset coincident with a strobe rise wins
    rst       = 1'b1;
    uio_in[2:0] = ADD;
    ui_in     = 8'h01;
    uio_in[3] = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    uio_in[3] = 1'b0;
    chk("rstfire_flags", uio_out, 8'h20);
    chk_acc("rstfire_acc", 16'h0000);
    @(negedge clk);
    chk("rstfire_flags2", uio_out, 8'h20);

    // Shift right
    do_op("ldlo_03", LDLO, 8'h03, 16'h0003, 8'h00);
    do_op("shr", SHR, 8'h00, 16'h0001, 8'h00);

    // Reset mid-sequence with overflow pending
`ifdef SUMMER_SATURATE_EN
    do_op("sub_05", SUB, 8'h05, 16'h0000, 8'h60);
`else
    do_op("sub_05", SUB, 8'h05, 16'hFFFC, 8'h40);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_uio", uio_out, 8'h20);
    chk_acc("rst2_acc", 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
